painterengine_gpu_dma_reader_scheduler: RTL and testbench

Sequences the GPU DMA reader and shares it among four requesters. It accepts per-channel read jobs (address, length) and arbitrates between them. For each granted job it restarts the reader through its reset and presents a one-hot router plus the job parameters. It then waits for the reader's done/error and retires the job with a per-channel completion or error pulse. It sits between the GPU command/texture fetch units and the single DMA reader instance.

---
 rtl/painterengine_gpu_pkg.sv | 24 ++
 rtl/painterengine_gpu_rr_arbiter.sv | 54 +++++
 rtl/painterengine_gpu_dma_reader_scheduler.sv | 144 ++++++++++++++
 tb/tb_painterengine_gpu_dma_reader_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared constants for the GPU DMA reader scheduler: channel count, FSM state
// encodings and the reader error codes reported on o_wire_error_type.
package painterengine_gpu_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    typedef enum logic [2:0] {
        ERR_OK           = 3'd0,
        ERR_ROUTER       = 3'd1,
        ERR_ADDRESS      = 3'd2,
        ERR_ADDR_TIMEOUT = 3'd3,
        ERR_DATA_TIMEOUT = 3'd4,
        ERR_PROTOCOL     = 3'd5
    } reader_err_e;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter.sv
// 4-way one-hot arbiter. Fixed priority (channel 0 highest) by default; a
// rotating priority pointer is added when PAINTERENGINE_GPU_SCHED_ROUND_ROBIN_EN is defined.
module painterengine_gpu_rr_arbiter
    import painterengine_gpu_pkg::*;
(
`ifdef PAINTERENGINE_GPU_SCHED_ROUND_ROBIN_EN
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_advance,
`endif
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_grant,
    output logic [1:0]        o_grant_idx
);

    logic [1:0] w_base;

`ifdef PAINTERENGINE_GPU_SCHED_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    // After a grant to g, priority starts at g+1 (2-bit wrap gives mod 4).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 2'd0;
        end else if (i_advance) begin
            r_ptr <= o_grant_idx + 2'd1;
        end
    end

    assign w_base = r_ptr;
`else
    assign w_base = 2'd0;
`endif

    always_comb begin : arb_scan
        logic [1:0] v_idx;
        logic       v_found;
        o_grant     = '0;
        o_grant_idx = '0;
        v_found     = 1'b0;
        v_idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v_idx = w_base + 2'(i);
            if (!v_found && i_req[v_idx]) begin
                v_found     = 1'b1;
                o_grant_idx = v_idx;
            end
        end
        if (v_found) begin
            o_grant = onehot4(o_grant_idx);
        end
    end

endmodule

// File: rtl/painterengine_gpu_dma_reader_scheduler.sv
// Shares one GPU DMA reader among four requesters: arbitrate, restart the reader, wait
// for done/error, retire. Optional round-robin via PAINTERENGINE_GPU_SCHED_ROUND_ROBIN_EN.
module painterengine_gpu_dma_reader_scheduler
    import painterengine_gpu_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 2
) (
    input  logic                 i_wire_clock,
    input  logic                 i_wire_resetn,
    input  logic [NUM_CH-1:0]    i_wire_req,
    input  logic [NUM_CH*32-1:0] i_wire_req_address,
    input  logic [NUM_CH*32-1:0] i_wire_req_length,
    output logic [NUM_CH-1:0]    o_wire_ack,
    output logic [NUM_CH-1:0]    o_wire_done,
    output logic [NUM_CH-1:0]    o_wire_error,
    output logic [2:0]           o_wire_error_type,
    output logic                 o_wire_busy,
    output logic                 o_wire_reader_resetn,
    output logic [NUM_CH-1:0]    o_wire_reader_router,
    output logic [NUM_CH*32-1:0] o_wire_reader_address,
    output logic [NUM_CH*32-1:0] o_wire_reader_length,
    input  logic                 i_wire_reader_done,
    input  logic                 i_wire_reader_error,
    input  logic [2:0]           i_wire_reader_error_type
);

    localparam int CNT_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_CH-1:0]    r_ack;
    logic [NUM_CH-1:0]    r_done;
    logic [NUM_CH-1:0]    r_error;
    logic [2:0]           r_error_type;
    logic                 r_busy;
    logic                 r_reader_resetn;
    logic [NUM_CH-1:0]    r_router;
    logic [NUM_CH*32-1:0] r_address;
    logic [NUM_CH*32-1:0] r_length;

    logic [NUM_CH-1:0]    w_grant;
    logic [1:0]           w_grant_idx;
    logic                 w_req_any;
    logic [6:0]           w_slot_lsb;

    assign w_req_any  = |i_wire_req;
    assign w_slot_lsb = {w_grant_idx, 5'd0};

`ifdef PAINTERENGINE_GPU_SCHED_ROUND_ROBIN_EN
    logic w_advance;
    assign w_advance = (r_state == ST_IDLE) && w_req_any;

    painterengine_gpu_rr_arbiter u_arbiter (
        .i_clk       (i_wire_clock),
        .i_rst_n     (i_wire_resetn),
        .i_advance   (w_advance),
        .i_req       (i_wire_req),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );
`else
    painterengine_gpu_rr_arbiter u_arbiter (
        .i_req       (i_wire_req),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );
`endif

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_ack           <= '0;
            r_done          <= '0;
            r_error         <= '0;
            r_error_type    <= '0;
            r_busy          <= 1'b0;
            r_reader_resetn <= 1'b0;
            r_router        <= '0;
            r_address       <= '0;
            r_length        <= '0;
        end else begin
            r_ack   <= '0;
            r_done  <= '0;
            r_error <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_ack                        <= w_grant;
                        r_router                     <= w_grant;
                        r_reader_resetn              <= 1'b1;
                        r_busy                       <= 1'b1;
                        r_state                      <= ST_RUN;
                        r_address                    <= '0;
                        r_address[w_slot_lsb +: 32]  <= i_wire_req_address[w_slot_lsb +: 32];
                        r_length                     <= '0;
                        r_length[w_slot_lsb +: 32]   <= i_wire_req_length[w_slot_lsb +: 32];
                    end
                end
                ST_RUN: begin
                    // Router stays put: the reader muxes its data path on it combinationally.
                    if (i_wire_reader_error || i_wire_reader_done) begin
                        if (i_wire_reader_error) begin
                            r_error      <= r_router;
                            r_error_type <= i_wire_reader_error_type;
                        end else begin
                            r_done <= r_router;
                        end
                        r_reader_resetn <= 1'b0;
                        r_router        <= '0;
                        r_cnt           <= HOLD_LOAD;
                        r_state         <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_busy          <= 1'b0;
                    r_reader_resetn <= 1'b0;
                    r_router        <= '0;
                end
            endcase
        end
    end

    assign o_wire_ack            = r_ack;
    assign o_wire_done           = r_done;
    assign o_wire_error          = r_error;
    assign o_wire_error_type     = r_error_type;
    assign o_wire_busy           = r_busy;
    assign o_wire_reader_resetn  = r_reader_resetn;
    assign o_wire_reader_router  = r_router;
    assign o_wire_reader_address = r_address;
    assign o_wire_reader_length  = r_length;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader_scheduler.sv
// Directed plus randomized bench for the DMA reader scheduler, checked against a
// job-level reference model (winner selection, pulse timing, held error code).
module tb_painterengine_gpu_dma_reader_scheduler;

    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_address;
    logic [127:0] req_length;
    logic [3:0]   ack, done, error;
    logic [2:0]   error_type;
    logic         busy, reader_resetn;
    logic [3:0]   reader_router;
    logic [127:0] reader_address, reader_length;
    logic         reader_done, reader_error;
    logic [2:0]   reader_error_type;

    painterengine_gpu_dma_reader_scheduler #(.RESET_HOLD_CYCLES(HOLD)) dut (
        .i_wire_clock             (clk),
        .i_wire_resetn            (rst_n),
        .i_wire_req               (req),
        .i_wire_req_address       (req_address),
        .i_wire_req_length        (req_length),
        .o_wire_ack               (ack),
        .o_wire_done              (done),
        .o_wire_error             (error),
        .o_wire_error_type        (error_type),
        .o_wire_busy              (busy),
        .o_wire_reader_resetn     (reader_resetn),
        .o_wire_reader_router     (reader_router),
        .o_wire_reader_address    (reader_address),
        .o_wire_reader_length     (reader_length),
        .i_wire_reader_done       (reader_done),
        .i_wire_reader_error      (reader_error),
        .i_wire_reader_error_type (reader_error_type)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] a [4];
    logic [31:0] l [4];
    int          m_ptr   = 0;
    logic [2:0]  m_etype = 3'd0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: lowest requesting index, or first from the pointer.
    function automatic int pick(input logic [3:0] r);
`ifdef PAINTERENGINE_GPU_SCHED_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) if (r[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
`else
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    function automatic logic [127:0] slot(input int g, input logic [31:0] v);
        logic [127:0] r;
        r = '0;
        r[g*32 +: 32] = v;
        return r;
    endfunction

    // One job from IDLE: grant, wait dly cycles, retire, flush; returns in IDLE.
    task automatic do_job(input logic [3:0] r, input int dly, input bit err, input bit dn,
                          input logic [2:0] et, input logic [3:0] flush_req);
        int         g;
        logic [3:0] oh;
        g  = pick(r);
        oh = 4'b0001 << g;
        for (int c = 0; c < 4; c++) begin
            req_address[c*32 +: 32] = a[c];
            req_length[c*32 +: 32]  = l[c];
        end
        req = r;
        tick();
        check("ack", {124'd0, ack}, {124'd0, oh});
        check("router", {124'd0, reader_router}, {124'd0, oh});
        check("reader_resetn_run", {127'd0, reader_resetn}, 128'd1);
        check("busy_run", {127'd0, busy}, 128'd1);
        check("reader_address", reader_address, slot(g, a[g]));
        check("reader_length", reader_length, slot(g, l[g]));
`ifdef PAINTERENGINE_GPU_SCHED_ROUND_ROBIN_EN
        m_ptr = (g + 1) % 4;
`endif
        req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            req_address[c*32 +: 32] = $urandom;
            req_length[c*32 +: 32]  = $urandom;
        end
        repeat (dly) tick();
        check("router_held", {124'd0, reader_router}, {124'd0, oh});
        check("no_early_retire", {120'd0, done, error}, 128'd0);
        reader_done       = dn | ~err;
        reader_error      = err;
        reader_error_type = et;
        tick();
        if (err) m_etype = et;
        check("done_pulse", {124'd0, done}, err ? 128'd0 : {124'd0, oh});
        check("error_pulse", {124'd0, error}, err ? {124'd0, oh} : 128'd0);
        check("error_type", {125'd0, error_type}, {125'd0, m_etype});
        check("reader_resetn_flush", {127'd0, reader_resetn}, 128'd0);
        check("router_flush", {124'd0, reader_router}, 128'd0);
        reader_done       = 1'b0;
        reader_error      = 1'b0;
        reader_error_type = 3'($urandom);
        req               = flush_req;
        repeat (HOLD - 1) begin
            tick();
            check("pulse_single", {120'd0, done, error}, 128'd0);
            check("busy_flush", {127'd0, busy}, 128'd1);
            check("no_ack_flush", {124'd0, ack}, 128'd0);
        end
        tick();
        check("busy_idle", {127'd0, busy}, 128'd0);
        check("reader_resetn_idle", {127'd0, reader_resetn}, 128'd0);
        check("error_type_held", {125'd0, error_type}, {125'd0, m_etype});
        check("no_ack_flush_end", {124'd0, ack}, 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        req               = '0;
        req_address       = '0;
        req_length        = '0;
        reader_done       = 1'b0;
        reader_error      = 1'b0;
        reader_error_type = '0;
        for (int c = 0; c < 4; c++) begin a[c] = $urandom; l[c] = $urandom; end
        repeat (3) tick();
        check("rst_outputs", {ack, done, error, error_type, busy, reader_resetn, reader_router},
              '0);
        check("rst_addr", reader_address | reader_length, 128'd0);
        rst_n = 1'b1;
        tick();

        // Channel 2, 0x1000 / 16 words, done roughly 20 cycles after the request.
        a[2] = 32'h0000_1000;
        l[2] = 32'd16;
        do_job(4'b0100, 18, 1'b0, 1'b1, 3'd0, 4'b0000);

        // All four requesting, five jobs back to back.
        for (int j = 0; j < 5; j++) do_job(4'b1111, 1, 1'b0, 1'b1, 3'($urandom), 4'b0000);

        // Error code 3 on channel 1, then a normal job.
        do_job(4'b0010, 3, 1'b1, 1'b0, 3'd3, 4'b0000);
        do_job(4'b1000, 2, 1'b0, 1'b1, 3'd6, 4'b0000);

        // Done and error together: error wins.
        do_job(4'b0001, 0, 1'b1, 1'b1, 3'd5, 4'b0000);

        // Request pulse that disappears before the first IDLE edge is dropped.
        do_job(4'b0001, 1, 1'b0, 1'b1, 3'd0, 4'b0100);
        req = 4'b0000;
        tick();
        check("dropped_req_ack", {124'd0, ack}, 128'd0);
        check("dropped_req_busy", {127'd0, busy}, 128'd0);

        // Request held through FLUSH is granted on the first IDLE edge.
        do_job(4'b0001, 1, 1'b0, 1'b1, 3'd0, 4'b0010);
        do_job(4'b0010, 2, 1'b0, 1'b1, 3'd0, 4'b0000);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            logic [3:0] r;
            bit         e;
            for (int c = 0; c < 4; c++) begin a[c] = $urandom; l[c] = $urandom; end
            r = 4'($urandom_range(1, 15));
            e = ($urandom_range(0, 2) == 0);
            do_job(r, $urandom_range(0, 5), e, 1'($urandom), 3'($urandom), 4'b0000);
        end

        // Asynchronous reset in the middle of a channel 0 job.
        req = 4'b0001;
        tick();
        check("pre_reset_ack", {124'd0, ack}, 128'd1);
        req = 4'b1000;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", {ack, done, error, busy, reader_resetn, reader_router}, '0);
        check("async_rst_etype", {125'd0, error_type}, 128'd0);
        m_etype = 3'd0;
        m_ptr   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_job(4'b1000, 2, 1'b0, 1'b1, 3'd0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
